// File: rtl/opl3_pkg.sv
// Shared types and default sizing for the OPL3 host interface and register file.
package opl3_pkg;

  localparam int REG_FILE_DATA_WIDTH     = 8;
  localparam int DEFAULT_HOST_FIFO_DEPTH = 8;
  localparam int DEFAULT_HOST_WR_SPACING = 4;

  typedef enum logic {
    PORT_ADDR = 1'b0,
    PORT_DATA = 1'b1
  } port_sel_e;

  typedef struct packed {
    logic                           valid;
    logic                           bank_num;
    logic [REG_FILE_DATA_WIDTH-1:0] address;
    logic [REG_FILE_DATA_WIDTH-1:0] data;
  } opl3_reg_wr_t;

  typedef struct packed {
    logic                           bank_num;
    logic [REG_FILE_DATA_WIDTH-1:0] address;
    logic [REG_FILE_DATA_WIDTH-1:0] data;
  } reg_wr_entry_t;

endpackage

// File: rtl/reg_wr_fifo.sv
// Register-write queue: power-of-two ring buffer with an occupancy count.
module reg_wr_fifo
  import opl3_pkg::*;
#(
  parameter int DEPTH = DEFAULT_HOST_FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  reg_wr_entry_t din_i,
  output reg_wr_entry_t dout_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam logic [CNTW-1:0] DEPTH_CNT = CNTW'(DEPTH);

  reg_wr_entry_t   mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == DEPTH_CNT);
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/host_if.sv
// Host port decode, paced register-write issue and status read path for the OPL3 core.
module host_if
  import opl3_pkg::*;
#(
  parameter int HOST_FIFO_DEPTH = DEFAULT_HOST_FIFO_DEPTH,
  parameter int HOST_WR_SPACING = DEFAULT_HOST_WR_SPACING
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [1:0]                     host_address,
  input  logic [REG_FILE_DATA_WIDTH-1:0] host_din,
  input  logic                           host_wr,
  input  logic                           host_rd,
  output logic [REG_FILE_DATA_WIDTH-1:0] host_dout,
  input  logic [REG_FILE_DATA_WIDTH-1:0] status,
  output opl3_reg_wr_t                   opl3_reg_wr,
  output logic                           wr_overflow
);

  localparam int CW = $clog2(HOST_WR_SPACING + 1);
  localparam logic [CW-1:0] SPACING_LOAD = CW'(HOST_WR_SPACING - 1);

  port_sel_e                      port_sel;
  logic                           bank_q, bank_d;
  logic [REG_FILE_DATA_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]                  space_q, space_d;
  logic                           ovf_q, ovf_d;
  logic [REG_FILE_DATA_WIDTH-1:0] dout_q, dout_d;
  opl3_reg_wr_t                   reg_wr_q, reg_wr_d;

  logic          push_req, fifo_push, fifo_pop, fifo_full, fifo_empty;
  reg_wr_entry_t fifo_din, fifo_dout;

  assign port_sel = port_sel_e'(host_address[0]);

  // Pop is decided first so a full queue can still accept a write in the same cycle.
  always_comb begin
    fifo_pop  = !fifo_empty && (space_q == '0);
    push_req  = host_wr && (port_sel == PORT_DATA);
    fifo_push = push_req && (!fifo_full || fifo_pop);
    fifo_din  = '{bank_num: bank_q, address: addr_q, data: host_din};
  end

  always_comb begin
    bank_d   = bank_q;
    addr_d   = addr_q;
    space_d  = space_q;
    ovf_d    = ovf_q | (push_req & ~fifo_push);
    dout_d   = dout_q;
    reg_wr_d = reg_wr_q;
    reg_wr_d.valid = 1'b0;

    if (host_wr && (port_sel == PORT_ADDR)) begin
      bank_d = host_address[1];
      addr_d = host_din;
    end

    if (fifo_pop) begin
      space_d  = SPACING_LOAD;
      reg_wr_d = '{valid: 1'b1, bank_num: fifo_dout.bank_num,
                   address: fifo_dout.address, data: fifo_dout.data};
    end else if (space_q != '0) begin
      space_d = space_q - 1'b1;
    end

    if (host_rd && !host_wr)
      dout_d = (port_sel == PORT_ADDR) ? status : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_q   <= 1'b0;
      addr_q   <= '0;
      space_q  <= '0;
      ovf_q    <= 1'b0;
      dout_q   <= '0;
      reg_wr_q <= '0;
    end else begin
      bank_q   <= bank_d;
      addr_q   <= addr_d;
      space_q  <= space_d;
      ovf_q    <= ovf_d;
      dout_q   <= dout_d;
      reg_wr_q <= reg_wr_d;
    end
  end

  reg_wr_fifo #(
    .DEPTH (HOST_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign host_dout   = dout_q;
  assign opl3_reg_wr = reg_wr_q;
  assign wr_overflow = ovf_q;

endmodule

// File: tb/tb_host_if.sv
// Scoreboard bench for host_if: two instances (spacing 4 and 16) share stimulus.
module tb_host_if;
  import opl3_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] haddr = '0;
  logic [7:0] hdin = '0;
  logic       hwr = 1'b0;
  logic       hrd = 1'b0;
  logic [7:0] status = '0;

  logic [7:0]   dout0, dout1;
  opl3_reg_wr_t rw0, rw1;
  logic         ovf0, ovf1;

  host_if #(.HOST_FIFO_DEPTH(8), .HOST_WR_SPACING(4)) dut0 (
    .clk(clk), .reset(rst), .host_address(haddr), .host_din(hdin), .host_wr(hwr),
    .host_rd(hrd), .host_dout(dout0), .status(status), .opl3_reg_wr(rw0), .wr_overflow(ovf0));

  host_if #(.HOST_FIFO_DEPTH(8), .HOST_WR_SPACING(16)) dut1 (
    .clk(clk), .reset(rst), .host_address(haddr), .host_din(hdin), .host_wr(hwr),
    .host_rd(hrd), .host_dout(dout1), .status(status), .opl3_reg_wr(rw1), .wr_overflow(ovf1));

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: per-instance queue of pending writes plus a cool-down timer.
  typedef struct {
    logic [16:0] e;
    int unsigned c;
  } exp_t;

  exp_t        exp0[$], exp1[$];
  logic [16:0] m_buf[2][8];
  int unsigned m_cnt[2], m_cd[2], m_rd[2];
  logic        m_ovf[2];
  logic [16:0] last[2], cap[2];
  int unsigned pcnt[2];
  logic        m_bank;
  logic [7:0]  m_addr, m_dout;
  int unsigned cyc = 0;

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_cd[k] = 0; m_rd[k] = 0; m_ovf[k] = 1'b0; last[k] = '0;
    end
    exp0.delete(); exp1.delete();
    m_bank = 1'b0; m_addr = '0; m_dout = '0;
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int unsigned sp = (k == 0) ? 4 : 16;
      bit pop = (m_cnt[k] != 0) && (m_cd[k] == 0);
      if (pop) begin
        exp_t x;
        x.e = m_buf[k][m_rd[k]];
        x.c = cyc;
        if (k == 0) exp0.push_back(x); else exp1.push_back(x);
        m_rd[k] = (m_rd[k] + 1) % 8;
        m_cnt[k]--;
        m_cd[k] = sp - 1;
      end else if (m_cd[k] > 0) begin
        m_cd[k]--;
      end
      if (hwr && haddr[0]) begin
        if (m_cnt[k] < 8) begin
          m_buf[k][(m_rd[k] + m_cnt[k]) % 8] = {m_bank, m_addr, hdin};
          m_cnt[k]++;
        end else begin
          m_ovf[k] = 1'b1;
        end
      end
    end
    if (hwr && !haddr[0]) begin
      m_bank = haddr[1];
      m_addr = hdin;
    end
    if (hrd && !hwr) m_dout = haddr[0] ? 8'h00 : status;
    cyc++;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_clear();
      else model_step();
    end
  end

  task automatic check_inst(input int k, input opl3_reg_wr_t rw, input logic ovf, input logic [7:0] dout);
    logic [16:0] got;
    exp_t x;
    got = {rw.bank_num, rw.address, rw.data};
    if (rw.valid) begin
      pcnt[k]++;
      cap[k] = got;
      if ((k == 0 && exp0.size() == 0) || (k == 1 && exp1.size() == 0)) begin
        chk($sformatf("unexpected_pulse%0d", k), 32'd1, 32'd0);
      end else begin
        x = (k == 0) ? exp0.pop_front() : exp1.pop_front();
        chk($sformatf("pulse_entry%0d", k), {15'd0, got}, {15'd0, x.e});
        chk($sformatf("pulse_cycle%0d", k), cyc - 1, x.c);
        last[k] = x.e;
      end
    end else begin
      chk($sformatf("hold_fields%0d", k), {15'd0, got}, {15'd0, last[k]});
    end
    chk($sformatf("overflow%0d", k), {31'd0, ovf}, {31'd0, m_ovf[k]});
    chk($sformatf("dout%0d", k), {24'd0, dout}, {24'd0, m_dout});
  endtask

  initial begin
    pcnt[0] = 0; pcnt[1] = 0; cap[0] = '0; cap[1] = '0;
    forever begin
      @(negedge clk);
      check_inst(0, rw0, ovf0, dout0);
      check_inst(1, rw1, ovf1, dout1);
    end
  end

  task automatic drive(input logic w, input logic r, input logic [1:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    hwr = w; hrd = r; haddr = a; hdin = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'b00, 8'h00);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    hwr = 1'b0; hrd = 1'b0; haddr = '0; hdin = '0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_imm_rw0", {15'd0, rw0}, 32'd0);
    chk("rst_imm_rw1", {15'd0, rw1}, 32'd0);
    chk("rst_imm_dout0", {24'd0, dout0}, 32'd0);
    chk("rst_imm_ovf1", {31'd0, ovf1}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  int unsigned p0, p1;

  initial begin
    #12;
    chk("reset_rw0", {15'd0, rw0}, 32'd0);
    chk("reset_dout0", {24'd0, dout0}, 32'd0);
    chk("reset_ovf0", {31'd0, ovf0}, 32'd0);
    #5 rst = 1'b0;
    idle(2);

    // Bank 0 write: one pulse, bank 0 / 0x04 / 0x80
    p0 = pcnt[0];
    drive(1'b1, 1'b0, 2'b00, 8'h04);
    drive(1'b1, 1'b0, 2'b01, 8'h80);
    idle(8);
    chk("bank0_count", pcnt[0] - p0, 32'd1);
    chk("bank0_entry", {15'd0, cap[0]}, {15'd0, 1'b0, 8'h04, 8'h80});

    // Bank 1 write
    drive(1'b1, 1'b0, 2'b10, 8'h05);
    drive(1'b1, 1'b0, 2'b11, 8'h01);
    idle(8);
    chk("bank1_entry", {15'd0, cap[0]}, {15'd0, 1'b1, 8'h05, 8'h01});

    // Back-to-back data writes reuse the latched address
    drive(1'b1, 1'b0, 2'b11, 8'h11);
    drive(1'b1, 1'b0, 2'b11, 8'h22);
    drive(1'b1, 1'b0, 2'b11, 8'h33);
    idle(20);
    chk("b2b_last", {15'd0, cap[0]}, {15'd0, 1'b1, 8'h05, 8'h33});

    // Status read path
    status = 8'hE0;
    drive(1'b0, 1'b1, 2'b00, 8'h00);
    idle(1);
    #4 chk("status_read", {24'd0, dout0}, 32'hE0);
    drive(1'b0, 1'b1, 2'b01, 8'h00);
    idle(1);
    #4 chk("data_read", {24'd0, dout0}, 32'h00);

    // Nine writes: freed slot accepts the ninth on both instances
    do_reset();
    p0 = pcnt[0]; p1 = pcnt[1];
    drive(1'b1, 1'b0, 2'b00, 8'h40);
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 2'b01, 8'(8'hA0 + i));
    idle(200);
    chk("nine_count0", pcnt[0] - p0, 32'd9);
    chk("nine_count1", pcnt[1] - p1, 32'd9);
    chk("nine_ovf1", {31'd0, ovf1}, 32'd0);

    // Ten writes with spacing 16 overflow once
    do_reset();
    p0 = pcnt[0]; p1 = pcnt[1];
    drive(1'b1, 1'b0, 2'b00, 8'h41);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 2'b01, 8'(8'hB0 + i));
    idle(200);
    chk("ten_count0", pcnt[0] - p0, 32'd10);
    chk("ten_count1", pcnt[1] - p1, 32'd9);
    chk("ten_ovf0", {31'd0, ovf0}, 32'd0);
    chk("ten_ovf1", {31'd0, ovf1}, 32'd1);

    // Reset with five entries queued drops them all
    do_reset();
    drive(1'b1, 1'b0, 2'b00, 8'h42);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 2'b01, 8'(8'hC0 + i));
    do_reset();
    p0 = pcnt[0]; p1 = pcnt[1];
    idle(40);
    chk("post_rst_pulses0", pcnt[0] - p0, 32'd0);
    chk("post_rst_pulses1", pcnt[1] - p1, 32'd0);

    // Randomized traffic, including simultaneous read and write
    do_reset();
    for (int i = 0; i < 600; i++) begin
      status = 8'($urandom);
      drive(1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) < 2),
            2'($urandom), 8'($urandom));
    end
    idle(200);
    chk("drain0", exp0.size(), 32'd0);
    chk("drain1", exp1.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
